// File: rtl/dmi_dtm_pkg.sv
// Shared types for the debug-transport data registers (DTMCS/DMI) and the
// request/response path toward the DMI clock-domain crossing.
package dmi_dtm_pkg;

  localparam int DmiDataWidth = 32;

  typedef enum logic [1:0] {
    DtmNop   = 2'd0,
    DtmRead  = 2'd1,
    DtmWrite = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DmiOk     = 2'd0,
    DmiFailed = 2'd2,
    DmiBusy   = 2'd3
  } dmi_status_e;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  typedef struct packed {
    dtm_op_e                 op;
    logic [DmiDataWidth-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [DmiDataWidth-1:0] data;
    logic [1:0]              resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_dr_shift.sv
// Generic JTAG data register: parallel capture, LSB-first serial shift.
module dmi_dr_shift #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             capture_i,
  input  logic             shift_i,
  input  logic             tdi_i,
  input  logic [Width-1:0] capture_data_i,
  output logic [Width-1:0] q_o,
  output logic             tdo_o
);

  logic [Width-1:0] sr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          sr_q <= '0;
    else if (capture_i) sr_q <= capture_data_i;
    else if (shift_i)   sr_q <= {tdi_i, sr_q[Width-1:1]};
  end

  assign q_o   = sr_q;
  assign tdo_o = sr_q[0];

endmodule

// File: rtl/dmi_jtag_dr.sv
// DTMCS/DMI data registers behind the TAP, turning DMI updates into
// valid/ready requests toward the DMI CDC and collecting responses.
module dmi_jtag_dr
  import dmi_dtm_pkg::*;
#(
  parameter int AddrWidth  = 7,
  parameter int IdleCycles = 1,
  parameter int DtmVersion = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tdi_i,
  input  logic                    capture_i,
  input  logic                    shift_i,
  input  logic                    update_i,
  input  logic                    dtmcs_select_i,
  input  logic                    dmi_select_i,
  output logic                    dtmcs_tdo_o,
  output logic                    dmi_tdo_o,
  output logic                    dmi_req_valid_o,
  input  logic                    dmi_req_ready_i,
  output logic [AddrWidth-1:0]    dmi_req_addr_o,
  output logic [1:0]              dmi_req_op_o,
  output logic [DmiDataWidth-1:0] dmi_req_data_o,
  input  logic                    dmi_resp_valid_i,
  output logic                    dmi_resp_ready_o,
  input  logic [DmiDataWidth-1:0] dmi_resp_data_i,
  input  logic [1:0]              dmi_resp_resp_i,
  output logic                    dmi_clear_o
);

  localparam int DmiWidth = AddrWidth + DmiDataWidth + 2;

  typedef enum logic [2:0] {Idle, Read, WaitRead, Write, WaitWrite} state_e;

  state_e                  state_q, state_d;
  dmi_status_e             error_q, error_d, dmi_stat;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [DmiDataWidth-1:0] data_q, data_d;
  logic                    clear_q;
  logic                    busy, req_valid, resp_ready;
  dtm_op_e                 req_op;
  dmi_req_t                req;
  dmi_resp_t               resp;

  logic [31:0]             dtmcs_sr;
  dtmcs_t                  dtmcs_q, dtmcs_cap;
  logic [DmiWidth-1:0]     dmi_q;
  logic                    dmi_capture, dmi_update, dmireset, hardreset;
  logic                    unused_dtmcs;

  assign busy        = (state_q != Idle);
  assign dmi_capture = capture_i & dmi_select_i;
  assign dmi_update  = update_i & dmi_select_i;
  assign dtmcs_q     = dtmcs_t'(dtmcs_sr);
  assign dmireset    = update_i & dtmcs_select_i & dtmcs_q.dmireset;
  assign hardreset   = update_i & dtmcs_select_i & dtmcs_q.dmihardreset;
  assign unused_dtmcs = ^{dtmcs_q.zero1, dtmcs_q.zero0, dtmcs_q.idle, dtmcs_q.dmistat,
                          dtmcs_q.abits, dtmcs_q.version};

  always_comb begin
    dtmcs_cap         = '0;
    dtmcs_cap.idle    = 3'(IdleCycles);
    dtmcs_cap.dmistat = error_q;
    dtmcs_cap.abits   = 6'(AddrWidth);
    dtmcs_cap.version = 4'(DtmVersion);
  end

  // A sticky error masks busy so the debugger sees the first failure.
  assign dmi_stat = (error_q != DmiOk) ? error_q : (busy ? DmiBusy : DmiOk);

  dmi_dr_shift #(.Width(32)) u_dtmcs (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .capture_i      (capture_i & dtmcs_select_i),
    .shift_i        (shift_i & dtmcs_select_i),
    .tdi_i          (tdi_i),
    .capture_data_i (dtmcs_cap),
    .q_o            (dtmcs_sr),
    .tdo_o          (dtmcs_tdo_o)
  );

  dmi_dr_shift #(.Width(DmiWidth)) u_dmi (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .capture_i      (dmi_capture),
    .shift_i        (shift_i & dmi_select_i),
    .tdi_i          (tdi_i),
    .capture_data_i ({addr_q, data_q, dmi_stat}),
    .q_o            (dmi_q),
    .tdo_o          (dmi_tdo_o)
  );

  assign resp = '{data: dmi_resp_data_i, resp: dmi_resp_resp_i};

  always_comb begin
    state_d    = state_q;
    error_d    = error_q;
    addr_d     = addr_q;
    data_d     = data_q;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    req_op     = DtmNop;
    unique case (state_q)
      Read: begin
        req_valid = 1'b1;
        req_op    = DtmRead;
        if (dmi_req_ready_i) state_d = WaitRead;
      end
      Write: begin
        req_valid = 1'b1;
        req_op    = DtmWrite;
        if (dmi_req_ready_i) state_d = WaitWrite;
      end
      WaitRead, WaitWrite: begin
        resp_ready = 1'b1;
        if (dmi_resp_valid_i) begin
          state_d = Idle;
          if (state_q == WaitRead) data_d = resp.data;
          if (resp.resp != 2'b00 && error_q != DmiBusy) error_d = DmiFailed;
        end
      end
      default: ;
    endcase
    if (dmi_capture && busy) error_d = DmiBusy;
    // An update landing on the completion cycle still sees busy and is dropped.
    if (dmi_update && error_q == DmiOk) begin
      if (busy) begin
        error_d = DmiBusy;
      end else if (dmi_q[1:0] == DtmRead) begin
        addr_d  = dmi_q[DmiWidth-1 -: AddrWidth];
        state_d = Read;
      end else if (dmi_q[1:0] == DtmWrite) begin
        addr_d  = dmi_q[DmiWidth-1 -: AddrWidth];
        data_d  = dmi_q[DmiDataWidth+1:2];
        state_d = Write;
      end
    end
    if (dmireset) error_d = DmiOk;
    if (hardreset) begin
      error_d = DmiOk;
      state_d = Idle;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Idle;
      error_q <= DmiOk;
      addr_q  <= '0;
      data_q  <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      clear_q <= hardreset;
    end
  end

  assign req              = '{op: req_op, data: data_q};
  assign dmi_req_valid_o  = req_valid;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_op_o     = req.op;
  assign dmi_req_data_o   = req.data;
  assign dmi_resp_ready_o = resp_ready;
  assign dmi_clear_o      = clear_q;

endmodule
